// File: rtl/mc14433_pkg.sv
// Shared types and constants for the MC14433 multiplexed-BCD reader.
// Holds the FSM states, strobe indices, range codes and the digit decode helpers.
package mc14433_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_S1      = 3'd1,
    ST_S2      = 3'd2,
    ST_S3      = 3'd3,
    ST_S4      = 3'd4,
    ST_PUBLISH = 3'd5
  } state_t;

  localparam int DS1_IDX = 0;
  localparam int DS2_IDX = 1;
  localparam int DS3_IDX = 2;
  localparam int DS4_IDX = 3;

  localparam logic [1:0] RANGE_OK  = 2'b00;
  localparam logic [1:0] RANGE_OVR = 2'b01;
  localparam logic [1:0] RANGE_UDR = 2'b10;

  typedef struct packed {
    logic       msd;
    logic       pos;
    logic       ovr;
    logic       udr;
    logic [3:0] dig2;
    logic [3:0] dig1;
    logic [3:0] dig0;
  } reading_t;

  // On the DS1 slot Q0 flags an out-of-range reading; Q3 then tells over from under.
  function automatic logic [1:0] range_code(input logic [3:0] q);
    if (!q[0]) begin
      return RANGE_OK;
    end else if (q[3]) begin
      return RANGE_UDR;
    end else begin
      return RANGE_OVR;
    end
  endfunction

  function automatic reading_t latch_digit(input reading_t rd, input logic [1:0] idx,
                                           input logic [3:0] q);
    reading_t r;
    r = rd;
    case (idx)
      2'd0: begin
        r.msd = ~q[3];
        r.pos = q[2];
        r.ovr = (range_code(q) == RANGE_OVR);
        r.udr = (range_code(q) == RANGE_UDR);
      end
      2'd1:    r.dig2 = q;
      2'd2:    r.dig1 = q;
      2'd3:    r.dig0 = q;
      default: r = rd;
    endcase
    return r;
  endfunction

  function automatic state_t strobe_state(input logic [1:0] idx);
    case (idx)
      2'd0:    return ST_S1;
      2'd1:    return ST_S2;
      2'd2:    return ST_S3;
      default: return ST_S4;
    endcase
  endfunction

  function automatic logic [1:0] strobe_index(input state_t s);
    case (s)
      ST_S2:   return 2'd1;
      ST_S3:   return 2'd2;
      ST_S4:   return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/mc14433_sync.sv
// Parameterized-width two-flop synchronizer with asynchronous active-low reset.
module mc14433_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two-stage resynchronization of an asynchronous bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mc14433_rd_capture.sv
// Captures one MC14433 conversion from the DS1..DS4 strobed BCD bus and publishes it
// as a registered reading with a one-cycle valid pulse, or a seq_err pulse on a bad frame.
module mc14433_rd_capture
  import mc14433_pkg::*;
#(
  parameter int SETTLE  = 3,
  parameter int TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] q_in,
  input  logic [3:0] ds_in,
  input  logic       eoc_in,
  output logic       msd,
  output logic [3:0] dig2,
  output logic [3:0] dig1,
  output logic [3:0] dig0,
  output logic       pos,
  output logic       ovr,
  output logic       udr,
  output logic       rd_valid,
  output logic       seq_err
);

  logic [1:0] rst_pipe;
  logic       rst_int_n;
  logic [3:0] q_s, ds_s, ds_d, rise, exp_mask;
  logic       eoc_sync_unused;
  logic       multi, fail, do_enter, do_latch;
  logic [1:0] idx, enter_idx, latch_idx;
  logic [15:0] gap, gap_nx, gap_inc;
  logic [3:0] cnt, cnt_nx;
  logic       latched, latched_nx, bad, bad_nx, rd_valid_nx, seq_err_nx;
  state_t     state, state_nx;
  reading_t   shadow, shadow_nx, rd, rd_nx;

  // Reset asserts asynchronously, releases two clocks later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_pipe <= 2'b00;
    end else begin
      rst_pipe <= {rst_pipe[0], 1'b1};
    end
  end
  assign rst_int_n = rst_pipe[1];

  mc14433_sync #(.WIDTH(4)) u_sync_q   (.clk(clk), .rst_n(rst_n), .d(q_in),   .q(q_s));
  mc14433_sync #(.WIDTH(4)) u_sync_ds  (.clk(clk), .rst_n(rst_n), .d(ds_in),  .q(ds_s));
  mc14433_sync #(.WIDTH(1)) u_sync_eoc (.clk(clk), .rst_n(rst_n), .d(eoc_in), .q(eoc_sync_unused));

  assign rise     = ds_s & ~ds_d;
  assign multi    = |(ds_s & (ds_s - 4'd1));
  assign idx      = strobe_index(state);
  assign exp_mask = latched ? (4'b0001 << (idx + 2'd1)) : 4'b0000;
  assign gap_inc  = (gap == 16'(TIMEOUT)) ? gap : gap + 16'd1;

  // Next-state, shadow capture and publish decisions.
  always_comb begin
    state_nx    = state;
    latched_nx  = latched;
    cnt_nx      = cnt;
    gap_nx      = gap;
    shadow_nx   = shadow;
    bad_nx      = bad;
    rd_nx       = rd;
    rd_valid_nx = 1'b0;
    seq_err_nx  = 1'b0;
    fail        = 1'b0;
    do_enter    = 1'b0;
    enter_idx   = 2'd0;
    do_latch    = 1'b0;
    latch_idx   = 2'd0;

    case (state)
      ST_IDLE: begin
        if (rise[DS1_IDX] && !multi) begin
          do_enter  = 1'b1;
          enter_idx = 2'(DS1_IDX);
        end else begin
          gap_nx = 16'd0;
        end
      end
      ST_S1, ST_S2, ST_S3, ST_S4: begin
        if (multi) begin
          fail = 1'b1;
        end else if (|(rise & ~exp_mask)) begin
          fail = 1'b1;
          if (rise[DS1_IDX]) begin
            do_enter  = 1'b1;
            enter_idx = 2'(DS1_IDX);
          end else begin
            do_enter = 1'b0;
          end
        end else if (!latched && !ds_s[idx]) begin
          fail = 1'b1;
        end else if (gap == 16'(TIMEOUT - 1)) begin
          fail = 1'b1;
        end else if (!latched) begin
          gap_nx = gap_inc;
          if (cnt == 4'(SETTLE - 1)) begin
            do_latch  = 1'b1;
            latch_idx = idx;
          end else begin
            cnt_nx = cnt + 4'd1;
          end
        end else if (|rise) begin
          do_enter  = 1'b1;
          enter_idx = idx + 2'd1;
          gap_nx    = gap_inc;
        end else begin
          gap_nx = gap_inc;
        end
      end
      ST_PUBLISH: begin
        if (bad) begin
          seq_err_nx = 1'b1;
        end else begin
          rd_nx       = shadow;
          rd_valid_nx = 1'b1;
        end
        state_nx = ST_IDLE;
        gap_nx   = 16'd0;
      end
      default: state_nx = ST_IDLE;
    endcase

    if (fail) begin
      seq_err_nx = 1'b1;
      state_nx   = ST_IDLE;
      latched_nx = 1'b0;
      cnt_nx     = 4'd0;
      gap_nx     = 16'd0;
    end else begin
      seq_err_nx = seq_err_nx;
    end

    // A DS1 rise always opens a fresh frame, even when it aborts one in progress.
    if (do_enter) begin
      if (enter_idx == 2'(DS1_IDX)) begin
        shadow_nx = '0;
        bad_nx    = 1'b0;
        gap_nx    = 16'd0;
      end else begin
        bad_nx = bad;
      end
      state_nx   = strobe_state(enter_idx);
      latched_nx = 1'b0;
      cnt_nx     = 4'd1;
      if (SETTLE == 1) begin
        do_latch  = 1'b1;
        latch_idx = enter_idx;
      end else begin
        do_latch = 1'b0;
      end
    end else begin
      cnt_nx = cnt_nx;
    end

    if (do_latch) begin
      shadow_nx = latch_digit(shadow_nx, latch_idx, q_s);
      if (latch_idx != 2'(DS1_IDX) && q_s > 4'd9) begin
        bad_nx = 1'b1;
      end else begin
        bad_nx = bad_nx;
      end
      gap_nx = 16'd0;
      cnt_nx = 4'd0;
      if (latch_idx == 2'(DS4_IDX)) begin
        state_nx   = ST_PUBLISH;
        latched_nx = 1'b0;
      end else begin
        latched_nx = 1'b1;
      end
    end else begin
      shadow_nx = shadow_nx;
    end
  end

  // State, counters, shadow and registered outputs.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state    <= ST_IDLE;
      ds_d     <= 4'b0000;
      latched  <= 1'b0;
      cnt      <= 4'd0;
      gap      <= 16'd0;
      shadow   <= '0;
      bad      <= 1'b0;
      rd       <= '0;
      rd_valid <= 1'b0;
      seq_err  <= 1'b0;
    end else begin
      state    <= state_nx;
      ds_d     <= ds_s;
      latched  <= latched_nx;
      cnt      <= cnt_nx;
      gap      <= gap_nx;
      shadow   <= shadow_nx;
      bad      <= bad_nx;
      rd       <= rd_nx;
      rd_valid <= rd_valid_nx;
      seq_err  <= seq_err_nx;
    end
  end

  assign msd  = rd.msd;
  assign pos  = rd.pos;
  assign ovr  = rd.ovr;
  assign udr  = rd.udr;
  assign dig2 = rd.dig2;
  assign dig1 = rd.dig1;
  assign dig0 = rd.dig0;

endmodule

// File: tb/tb_mc14433_rd_capture.sv
// Randomized frame-level bench for mc14433_rd_capture with a digit-decode reference model.
module tb_mc14433_rd_capture;

  localparam int SETTLE  = 3;
  localparam int TIMEOUT = 200;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] q_in, ds_in;
  logic       eoc_in;
  logic       msd, pos, ovr, udr, rd_valid, seq_err;
  logic [3:0] dig2, dig1, dig0;
  logic [15:0] rd_bus, exp_rd;

  int n_checks = 0, n_fail = 0, cyc = 0;
  int n_valid = 0, n_err = 0, n_bad_pulse = 0, valid_cyc = 0, err_cyc = 0;
  logic prev_valid = 1'b0, prev_err = 1'b0;

  mc14433_rd_capture #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .q_in(q_in), .ds_in(ds_in), .eoc_in(eoc_in),
    .msd(msd), .dig2(dig2), .dig1(dig1), .dig0(dig0), .pos(pos), .ovr(ovr), .udr(udr),
    .rd_valid(rd_valid), .seq_err(seq_err)
  );

  assign rd_bus = {msd, pos, ovr, udr, dig2, dig1, dig0};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: counts pulses and flags overlap or pulses wider than one cycle.
  always @(negedge clk) begin
    if (rd_valid) begin n_valid++; valid_cyc = cyc; end
    if (seq_err)  begin n_err++;   err_cyc = cyc;   end
    if ((rd_valid && seq_err) || (rd_valid && prev_valid) || (seq_err && prev_err)) n_bad_pulse++;
    prev_valid = rd_valid;
    prev_err   = seq_err;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected reading from the MC14433 digit rules, packed as {msd,pos,ovr,udr,d2,d1,d0}.
  function automatic logic [15:0] model(input int q1, input int d2, input int d1, input int d0);
    int m, p, o, u;
    m = (q1 < 8) ? 1 : 0;
    p = (q1 / 4) % 2;
    o = (q1 % 2 == 1 && q1 < 8) ? 1 : 0;
    u = (q1 % 2 == 1 && q1 >= 8) ? 1 : 0;
    return 16'((m * 8 + p * 4 + o * 2 + u) * 4096 + d2 * 256 + d1 * 16 + d0);
  endfunction

  task automatic drive_strobe(input int idx, input int q, input int hold, output int drv);
    @(posedge clk); #1;
    q_in  = 4'(q);
    ds_in = 4'b0001 << idx;
    drv   = cyc;
    for (int i = 1; i < hold; i++) begin
      @(posedge clk); #1;
      if (i == SETTLE + 6) q_in = 4'($urandom);
    end
    @(posedge clk); #1;
    ds_in  = 4'b0000;
    q_in   = 4'($urandom);
    eoc_in = 1'($urandom);
    repeat ($urandom_range(4, 1)) @(posedge clk);
  endtask

  task automatic run_frame(input int q1, input int d2, input int d1, input int d0, output int c4);
    int t;
    drive_strobe(0, q1, 20, t);
    drive_strobe(1, d2, 20, t);
    drive_strobe(2, d1, 20, t);
    drive_strobe(3, d0, 20, c4);
  endtask

  task automatic good_frame(input string tag, input int q1, input int d2, input int d1, input int d0);
    int v0, e0, c4;
    v0 = n_valid; e0 = n_err;
    run_frame(q1, d2, d1, d0, c4);
    repeat (8) @(posedge clk); #1;
    exp_rd = model(q1, d2, d1, d0);
    check({tag, "_valid_cnt"}, n_valid - v0, 1);
    check({tag, "_err_cnt"}, n_err - e0, 0);
    check({tag, "_reading"}, rd_bus, exp_rd);
    check({tag, "_latency"}, valid_cyc, c4 + SETTLE + 3);
  endtask

  task automatic bad_frame(input string tag, input int q1, input int d2, input int d1, input int d0);
    int v0, e0, c4;
    v0 = n_valid; e0 = n_err;
    run_frame(q1, d2, d1, d0, c4);
    repeat (8) @(posedge clk); #1;
    check({tag, "_valid_cnt"}, n_valid - v0, 0);
    check({tag, "_err_cnt"}, n_err - e0, 1);
    check({tag, "_held"}, rd_bus, exp_rd);
  endtask

  initial begin
    int v0, e0, t, c2, c4, p0;
    int d[3];
    rst_n = 1'b1; q_in = 4'd0; ds_in = 4'd0; eoc_in = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("reset_reading", rd_bus, 16'd0);
    check("reset_pulses", {rd_valid, seq_err}, 2'b00);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    exp_rd = 16'd0;

    good_frame("nominal", 4, 1, 9, 9);
    check("nominal_flags", rd_bus[15:12], 4'b1100);
    good_frame("neg_ovr", 1, 0, 0, 0);
    check("neg_ovr_flags", rd_bus[15:12], 4'b1010);

    for (int i = 0; i < 6; i++)
      good_frame("rand_good", int'($urandom_range(15, 0)), int'($urandom_range(9, 0)),
                 int'($urandom_range(9, 0)), int'($urandom_range(9, 0)));

    bad_frame("ds3_1010", 4, 1, 10, 9);
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) d[j] = int'($urandom_range(9, 0));
      d[$urandom_range(2, 0)] = int'($urandom_range(15, 10));
      bad_frame("rand_bad_digit", int'($urandom_range(15, 0)), d[0], d[1], d[2]);
    end

    // DS1, DS2, then DS4 out of order.
    v0 = n_valid; e0 = n_err;
    drive_strobe(0, 4, 20, t);
    drive_strobe(1, 5, 20, t);
    drive_strobe(3, 7, 20, t);
    repeat (8) @(posedge clk); #1;
    check("ooo_err_cnt", n_err - e0, 1);
    check("ooo_valid_cnt", n_valid - v0, 0);
    check("ooo_held", rd_bus, exp_rd);
    good_frame("after_ooo", 12, 3, 4, 5);

    // DS2 held shorter than SETTLE.
    v0 = n_valid; e0 = n_err;
    drive_strobe(0, 4, 20, t);
    drive_strobe(1, 3, SETTLE - 1, t);
    repeat (8) @(posedge clk); #1;
    check("short_err_cnt", n_err - e0, 1);
    check("short_valid_cnt", n_valid - v0, 0);
    check("short_held", rd_bus, exp_rd);

    // An early DS1 rise aborts the frame and restarts capture.
    v0 = n_valid; e0 = n_err;
    drive_strobe(0, 9, 20, t);
    drive_strobe(1, 2, 20, t);
    run_frame(6, 8, 0, 7, c4);
    repeat (8) @(posedge clk); #1;
    exp_rd = model(6, 8, 0, 7);
    check("restart_err_cnt", n_err - e0, 1);
    check("restart_valid_cnt", n_valid - v0, 1);
    check("restart_reading", rd_bus, exp_rd);

    // DS3 never arrives.
    v0 = n_valid; e0 = n_err;
    drive_strobe(0, 0, 20, t);
    drive_strobe(1, 6, 20, c2);
    repeat (TIMEOUT + 20) @(posedge clk); #1;
    check("timeout_err_cnt", n_err - e0, 1);
    check("timeout_cycle", err_cyc, c2 + 2 + SETTLE + TIMEOUT);
    check("timeout_valid_cnt", n_valid - v0, 0);
    good_frame("after_timeout", 8, 9, 8, 7);

    // Asynchronous reset while settling on DS3.
    p0 = n_valid + n_err;
    drive_strobe(0, 4, 20, t);
    drive_strobe(1, 1, 20, t);
    @(posedge clk); #1;
    q_in = 4'd2; ds_in = 4'b0100;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_mid_reading", rd_bus, 16'd0);
    check("rst_mid_pulses", {rd_valid, seq_err}, 2'b00);
    ds_in = 4'b0000;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (6) @(posedge clk); #1;
    check("rst_mid_no_pulse", n_valid + n_err, p0);
    exp_rd = 16'd0;
    good_frame("after_rst", 13, 2, 5, 0);

    check("pulse_exclusive_width", n_bad_pulse, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
